// File: rtl/clk_div_inv_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_inv_if
// Description : Control/status bundle for the multi-channel clock
//               divider/inverter. Master drives run/load controls and per-channel
//               divide/invert values. Slave returns the divided outputs, edge
//               strobes and pending-update flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_inv_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic                      en;
    logic                      load;
    logic [CHANNELS*WIDTH-1:0] div;
    logic [CHANNELS-1:0]       inv;
    logic [CHANNELS-1:0]       out;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       pend;

    modport master (
        output en, load, div, inv,
        input  out, tick, pend
    );

    modport slave (
        input  en, load, div, inv,
        output out, tick, pend
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_inv.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_inv
// Description : Multi-channel programmable clock divider/inverter. Each channel
//               produces a 50% duty square wave with half-period div+1 cycles,
//               optional inversion and a one-cycle rising-phase strobe.
//               Ratio/polarity updates are staged and only applied at a
//               half-period boundary (or at once while halted), so no runt
//               pulses are produced.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_inv #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    clk_div_inv_if.slave   bus
);

    logic [CHANNELS-1:0] w_out;
    logic [CHANNELS-1:0] w_tick;
    logic [CHANNELS-1:0] w_pend;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] w_div_in;
            logic [WIDTH-1:0] r_cnt;
            logic             r_q;
            logic [WIDTH-1:0] r_div_act;
            logic             r_inv_act;
            logic [WIDTH-1:0] r_div_pend;
            logic             r_inv_pend;
            logic             r_pend;
            logic             r_out;
            logic             r_tick;
            logic             w_boundary;

            assign w_div_in   = bus.div[i*WIDTH +: WIDTH];
            assign w_boundary = (r_cnt == r_div_act);

            // Per-channel counter, phase, staged update and registered outputs.
            // A load in the same cycle as an apply re-arms pend with the new
            // values; the apply itself always consumes the previously held ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt      <= '0;
                    r_q        <= 1'b0;
                    r_div_act  <= '0;
                    r_inv_act  <= 1'b0;
                    r_div_pend <= '0;
                    r_inv_pend <= 1'b0;
                    r_pend     <= 1'b0;
                    r_out      <= 1'b0;
                    r_tick     <= 1'b0;
                end else begin
                    if (bus.load) begin
                        r_div_pend <= w_div_in;
                        r_inv_pend <= bus.inv[i];
                        r_pend     <= 1'b1;
                    end

                    if (bus.en) begin
                        if (!w_boundary) begin
                            r_cnt  <= r_cnt + WIDTH'(1);
                            r_tick <= 1'b0;
                        end else begin
                            r_cnt  <= '0;
                            r_q    <= ~r_q;
                            r_tick <= ~r_q;
                            if (r_pend) begin
                                r_div_act <= r_div_pend;
                                r_inv_act <= r_inv_pend;
                                r_out     <= ~r_q ^ r_inv_pend;
                                if (!bus.load) begin
                                    r_pend <= 1'b0;
                                end
                            end else begin
                                r_out <= ~r_q ^ r_inv_act;
                            end
                        end
                    end else begin
                        // Halted: counter and phase freeze, but a staged update
                        // is safe to apply immediately since no edge is in flight.
                        r_tick <= 1'b0;
                        if (r_pend) begin
                            r_div_act <= r_div_pend;
                            r_inv_act <= r_inv_pend;
                            r_out     <= r_q ^ r_inv_pend;
                            if (!bus.load) begin
                                r_pend <= 1'b0;
                            end
                        end
                    end
                end
            end

            assign w_out[i]  = r_out;
            assign w_tick[i] = r_tick;
            assign w_pend[i] = r_pend;
        end
    endgenerate

    assign bus.out  = w_out;
    assign bus.tick = w_tick;
    assign bus.pend = w_pend;

endmodule
`default_nettype wire
